// File: rtl/config_stream_loader.sv
// Configuration bitstream loader: packs 8-byte records (addr then data, LSB first)
// into single-cycle writes on the fabric-wide configuration bus.
module config_stream_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        config_done,
    output logic [15:0] config_count
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] IDLE_ADDR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] TERM_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        byte_idx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              accept;

    // in_ready mirrors COLLECT, so a transfer is decided from state alone
    assign accept = in_valid && (state == COLLECT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= COLLECT;
            byte_idx     <= 3'd0;
            addr_q       <= '0;
            data_q       <= '0;
            in_ready     <= 1'b1;
            config_addr  <= IDLE_ADDR;
            config_data  <= '0;
            config_done  <= 1'b0;
            config_count <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        byte_idx <= byte_idx + 3'd1;
                        if (!byte_idx[2]) begin
                            addr_q[{byte_idx[1:0], 3'b000} +: 8] <= in_data;
                        end else begin
                            data_q[{byte_idx[1:0], 3'b000} +: 8] <= in_data;
                        end
                        // Last byte: address is complete; data top byte comes straight from the input
                        if (byte_idx == 3'd7) begin
                            in_ready <= 1'b0;
                            if (addr_q == TERM_ADDR) begin
                                state       <= DONE;
                                config_done <= 1'b1;
                            end else begin
                                state       <= ISSUE;
                                config_addr <= addr_q;
                                config_data <= {in_data, data_q[23:0]};
                            end
                        end
                    end
                end
                ISSUE: begin
                    state       <= COLLECT;
                    in_ready    <= 1'b1;
                    config_addr <= IDLE_ADDR;
                    config_data <= '0;
                    if (config_count != {CNT_W{1'b1}}) begin
                        config_count <= config_count + 16'd1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                end
                default: begin
                    state       <= COLLECT;
                    in_ready    <= 1'b1;
                    config_addr <= IDLE_ADDR;
                    config_data <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_stream_loader.sv
// Self-checking bench for config_stream_loader: scoreboard of expected bus pulses
// matched against pulses seen on the configuration bus.
module tb_config_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_done;
    logic [15:0] config_count;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    config_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_done  (config_done),
        .config_count (config_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Any non-idle bus value is a write pulse and must match the oldest expected record
    always @(negedge clk) begin
        if (config_addr != 32'h0 || config_data != 32'h0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", {config_addr, config_data}, 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("pulse_addr", config_addr, e.addr);
                check_eq("pulse_data", config_data, e.data);
                check_eq("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Entered on a negedge; returns just after the accepting rising edge
    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        in_valid = 1'b1;
        in_data  = b;
        acc_cyc  = -1;
        for (int k = 0; k < 40; k++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc_cyc < 0) check_eq("ready_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_record(input logic [31:0] addr, input logic [31:0] data,
                               input bit gap, output int first_c, output int last_c);
        logic [63:0] rec;
        int c;
        rec = {data, addr};
        first_c = -1;
        last_c  = -1;
        for (int i = 0; i < 8; i++) begin
            send_byte(rec[8*i +: 8], c);
            if (i == 0) first_c = c;
            if (i == 7) begin
                last_c = c;
                if (addr != 32'hFFFF_FFFF && c >= 0) sb.push_back('{addr, data, 32'(c)});
            end
            @(negedge clk);
            if (gap && i < 7) begin
                check_eq("ready_gap", in_ready, 1);
                @(negedge clk);
            end
        end
        check_eq("ready_after_last", in_ready, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l, l1, l2, l3, c;
        logic [63:0] rec;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_addr", config_addr, 0);
        check_eq("rst_data", config_data, 0);
        check_eq("rst_done", config_done, 0);
        check_eq("rst_count", config_count, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single record, valid held high
        send_record(32'h0007_0003, 32'h0000_0005, 1'b0, f, l);
        check_eq("t1_span", l - f, 7);
        @(negedge clk);
        check_eq("t1_idle_addr", config_addr, 0);
        check_eq("t1_count", config_count, 1);

        // Same record with idle cycles between bytes
        send_record(32'h0007_0003, 32'h0000_0005, 1'b1, f, l);
        check_eq("t2_span", l - f, 14);
        @(negedge clk);
        check_eq("t2_count", config_count, 2);

        // Three back-to-back records then terminator
        do_reset();
        send_record(32'h0007_0002, 32'h1111_2222, 1'b0, f, l1);
        send_record(32'h0006_0002, 32'hA5A5_0F0F, 1'b0, f, l2);
        send_record(32'h0004_0002, 32'hDEAD_BEEF, 1'b0, f, l3);
        check_eq("t3_spacing_a", l2 - l1, 9);
        check_eq("t3_spacing_b", l3 - l2, 9);
        send_record(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, f, l);
        check_eq("t3_done", config_done, 1);
        check_eq("t3_count", config_count, 3);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (10) @(negedge clk);
        check_eq("t3_ready_held", in_ready, 0);
        in_valid = 1'b0;
        check_eq("t3_count_after", config_count, 3);
        check_eq("t3_done_sticky", config_done, 1);

        // Reset after byte 5 discards the partial record
        do_reset();
        rec = {32'h0BAD_F00D, 32'h0005_0009};
        for (int i = 0; i < 6; i++) begin
            send_byte(rec[8*i +: 8], c);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_record(32'h0007_0001, 32'h0000_0042, 1'b0, f, l);
        @(negedge clk);
        check_eq("t4_count", config_count, 1);

        // Reset during ISSUE returns the bus to idle without a clock edge
        do_reset();
        rec = {32'h0000_00C3, 32'h0006_0003};
        for (int i = 0; i < 7; i++) begin
            send_byte(rec[8*i +: 8], c);
            @(negedge clk);
        end
        send_byte(rec[63:56], c);
        check_eq("t5_issue_addr", config_addr, 32'h0006_0003);
        check_eq("t5_issue_data", config_data, 32'h0000_00C3);
        reset = 1'b0;
        #1;
        check_eq("t5_abort_addr", config_addr, 0);
        check_eq("t5_abort_data", config_data, 0);
        check_eq("t5_abort_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        check_eq("t5_count", config_count, 0);

        // Counter saturation
        do_reset();
        force dut.config_count = 16'hFFFF;
        #1;
        release dut.config_count;
        check_eq("t6_preload", config_count, 16'hFFFF);
        send_record(32'h0005_0004, 32'h1234_5678, 1'b0, f, l);
        @(negedge clk);
        check_eq("t6_count_sat", config_count, 16'hFFFF);

        @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
